multicycle_main_controller: RTL and testbench
=============================================

// Module: multicycle_main_controller
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit IR opcode and sequences
//  fetch/decode/execute/memory/writeback. Drives the 2-bit alu_op consumed by the ALU controller
//  (MTYPE 00 add, BTYPE 01 sub, RTYPE 10 use func, JTYPE 11 off) plus all datapath enables.
//  Waits on a memory-ready handshake and counts retired instructions.
// PARAMETERS
//  RETIRE_W  32  width of the retired-instruction counter (wraps modulo 2^RETIRE_W)
// PORTS
//  clk            in   1  rising-edge clock; the only clock
//  rst_n          in   1  reset, asynchronous and active-low
//  opcode         in   6  IR[31:26], stable from DECODE until the next FETCH
//  mem_ready      in   1  memory has completed the current read/write this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (beq)
//  pc_src         out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
//  i_or_d         out  1  memory address: 0 = PC, 1 = ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  load IR from memory data
//  reg_dst        out  1  write register: 0 = rt, 1 = rd
//  mem_to_reg     out  1  write data: 0 = ALUOut, 1 = MDR
//  reg_write      out  1  register file write enable
//  alu_src_a      out  1  0 = PC, 1 = A
//  alu_src_b      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
//  alu_op         out  2  to ALU controller, encodings as above
//  illegal_op     out  1  one-cycle pulse in DECODE when opcode is unsupported
//  retired        out  RETIRE_W  count of completed instructions
// BEHAVIOUR
//  - Moore outputs: registered state, outputs decoded combinationally from state (+ mem_ready, opcode
//    where noted). Any output not listed for a state is 0.
//  - rst_n low: state -> S_RESET immediately; all outputs 0; retired = 0. Holds for a mid-transfer
//    memory access too: mem_read/mem_write drop asynchronously.
//  - States / outputs / transitions:
//    S_RESET  : all 0                                          -> FETCH
//    FETCH    : mem_read, i_or_d=0, src_a=0, src_b=01, alu_op=00,
//               pc_src=00, ir_write=pc_write=mem_ready          -> DECODE if mem_ready, else stay
//    DECODE   : src_a=0, src_b=11, alu_op=00 (branch target)   -> by opcode:
//               000000 R -> EXEC_R; 100011 lw, 101011 sw -> MEM_ADDR; 001000 addi -> EXEC_I;
//               000100 beq -> BRANCH; 000010 j -> JUMP; other -> FETCH with illegal_op=1
//    MEM_ADDR : src_a=1, src_b=10, alu_op=00                   -> MEM_RD (lw) / MEM_WR (sw)
//    MEM_RD   : mem_read, i_or_d=1                             -> WB_MEM if mem_ready, else stay
//    WB_MEM   : reg_write, mem_to_reg=1, reg_dst=0             -> FETCH
//    MEM_WR   : mem_write, i_or_d=1                            -> FETCH if mem_ready, else stay
//    EXEC_R   : src_a=1, src_b=00, alu_op=10                   -> WB_R
//    WB_R     : reg_write, reg_dst=1, mem_to_reg=0             -> FETCH
//    EXEC_I   : src_a=1, src_b=10, alu_op=00                   -> WB_I
//    WB_I     : reg_write, reg_dst=0, mem_to_reg=0             -> FETCH
//    BRANCH   : src_a=1, src_b=00, alu_op=01, pc_write_cond, pc_src=01 -> FETCH
//    JUMP     : pc_write, pc_src=10, alu_op=11                 -> FETCH
//  - Latency with zero-wait memory: R/addi 4, lw 5, sw 4, beq/j 3 cycles.
//  - retired increments by 1 on each transition into FETCH from WB_MEM, MEM_WR (on mem_ready), WB_R,
//    WB_I, BRANCH or JUMP. It does not increment for illegal opcodes or on S_RESET -> FETCH.
//    It wraps all-ones -> 0.
//  - mem_ready is sampled only in FETCH/MEM_RD/MEM_WR; it is ignored elsewhere. An unbounded stall
//    is legal: the FSM holds and its outputs stay constant.
//  - Unreachable state encodings -> S_RESET on the next clock.
// STRUCTURE
//  - alu_op encodings (MTYPE/BTYPE/RTYPE/JTYPE) and opcode constants go in the shared
//    constant_values.h. State encodings stay local parameters.
//  - Single module; no sub-module. Three processes: state register, next-state logic, output decode.
// TESTING
//  - Reset: rst_n=0 for 2 cycles, then release -> all outputs 0 and retired=0 while rst_n=0; on the
//    first clock FETCH is entered with mem_read=1.
//  - R-type: opcode=000000, mem_ready=1 always -> alu_op=10 in cycle 3, reg_write & reg_dst=1 in
//    cycle 4, retired=1.
//  - lw with 3-cycle stall in MEM_RD: mem_read and i_or_d=1 are held 3 cycles; WB_MEM has
//    mem_to_reg=1; retired increments once.
//  - beq then j: BRANCH shows alu_op=01, pc_write_cond=1, pc_src=01; JUMP shows pc_write=1,
//    pc_src=10; retired += 2.
//  - opcode=111111 -> illegal_op=1 for exactly 1 cycle, back to FETCH, retired unchanged.
//  - rst_n dropped during MEM_WR stall -> mem_write=0 in the same cycle; restart fetches from FETCH;
//    retired=0.

Source files
------------

// File: rtl/multicycle_main_controller_pkg.sv
// Shared encodings for the multicycle MIPS main controller: ALU-controller
// operation classes and the opcodes the controller decodes.
package multicycle_main_controller_pkg;

  localparam logic [1:0] ALU_MTYPE = 2'b00;  // add (address / PC arithmetic)
  localparam logic [1:0] ALU_BTYPE = 2'b01;  // subtract (beq compare)
  localparam logic [1:0] ALU_RTYPE = 2'b10;  // use func field
  localparam logic [1:0] ALU_JTYPE = 2'b11;  // ALU unused

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and counts retired instructions.
module multicycle_main_controller
  import multicycle_main_controller_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          dbg_state
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Memory handshake: mem_request (mem_read/mem_write) is held asserted while
  // in FETCH/MEM_RD/MEM_WR; the access completes in the cycle mem_ready is 1,
  // and the FSM advances on that edge. mem_ready is ignored in all other states.
  always_comb begin
    state_d = S_RESET;
    retire  = 1'b0;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: begin
        state_d = mem_ready ? S_FETCH : S_MEM_WR;
        retire  = mem_ready;
      end
      S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      default:    state_d = S_RESET;
    endcase
    retired_d = retired_q + RETIRE_W'(retire);
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_MTYPE;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !is_legal_op(opcode);
      end
      S_MEM_ADDR, S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_WB_I:     reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_BTYPE;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        alu_op   = ALU_JTYPE;
      end
      default: ;
    endcase
  end

  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for multicycle_main_controller: a per-cycle vector table for
// every instruction class plus hand sequences for stalls and mid-access reset.
module tb_multicycle_main_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'b0;
  logic        mem_ready = 1'b0;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [31:0] retired;
  logic [3:0]  dbg_state;

  logic        w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
  logic        w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a, w_illegal_op;
  logic [1:0]  w_pc_src, w_alu_src_b, w_alu_op;
  logic [1:0]  w_retired;
  logic [3:0]  w_dbg_state;

  int total = 0;
  int bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  multicycle_main_controller #(.RETIRE_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .retired(retired),
    .dbg_state(dbg_state)
  );

  // Narrow counter copy so the wrap from all-ones to zero is reachable.
  multicycle_main_controller #(.RETIRE_W(2)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .pc_src(w_pc_src),
    .i_or_d(w_i_or_d), .mem_read(w_mem_read), .mem_write(w_mem_write),
    .ir_write(w_ir_write), .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
    .reg_write(w_reg_write), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
    .alu_op(w_alu_op), .illegal_op(w_illegal_op), .retired(w_retired),
    .dbg_state(w_dbg_state)
  );

  // {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
  //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op}
  function automatic logic [16:0] mk(
    input logic pcw, input logic pcwc, input logic [1:0] pcs, input logic iod,
    input logic mr, input logic mw, input logic irw, input logic rd,
    input logic m2r, input logic rw, input logic sa, input logic [1:0] sb,
    input logic [1:0] aop, input logic ill);
    return {pcw, pcwc, pcs, iod, mr, mw, irw, rd, m2r, rw, sa, sb, aop, ill};
  endfunction

  logic [16:0] got_ctl, got_ctl_w;
  assign got_ctl = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                    ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                    alu_op, illegal_op};
  assign got_ctl_w = {w_pc_write, w_pc_write_cond, w_pc_src, w_i_or_d, w_mem_read,
                      w_mem_write, w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write,
                      w_alu_src_a, w_alu_src_b, w_alu_op, w_illegal_op};

  logic [16:0] e_zero, e_fetch0, e_fetch1, e_decode, e_decode_ill, e_mem_addr;
  logic [16:0] e_mem_rd, e_wb_mem, e_mem_wr, e_exec_r, e_wb_r, e_exec_i, e_wb_i;
  logic [16:0] e_branch, e_jump;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [16:0] exp;
    int unsigned ret;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [5:0] op, input logic mr,
                              input logic [16:0] exp, input int unsigned ret);
    vec_t v;
    v.op = op; v.mr = mr; v.exp = exp; v.ret = ret;
    tbl.push_back(v);
  endfunction

  // scoreboard
  task automatic check_all(input string name, input logic [16:0] exp,
                           input int unsigned exp_ret);
    logic [1:0] exp_ret_w;
    exp_ret_w = exp_ret[1:0];
    total++;
    if (got_ctl !== exp) begin
      bad++;
      $display("FAIL %s ctl: got %05h exp %05h", name, got_ctl, exp);
    end
    total++;
    if (retired !== exp_ret) begin
      bad++;
      $display("FAIL %s retired: got %0d exp %0d", name, retired, exp_ret);
    end
    total++;
    if (got_ctl_w !== exp || w_retired !== exp_ret_w) begin
      bad++;
      $display("FAIL %s narrow: got ctl %05h ret %0d exp ctl %05h ret %0d",
               name, got_ctl_w, w_retired, exp, exp_ret_w);
    end
  endtask

  // driver: apply inputs after the falling edge, check, then let the rising edge act
  task automatic step(input string name, input logic [5:0] op, input logic mr,
                      input logic [16:0] exp, input int unsigned exp_ret);
    @(negedge clk);
    opcode = op;
    mem_ready = mr;
    #1;
    check_all(name, exp, exp_ret);
  endtask

  localparam logic [5:0] O_R    = 6'b000000;
  localparam logic [5:0] O_LW   = 6'b100011;
  localparam logic [5:0] O_SW   = 6'b101011;
  localparam logic [5:0] O_ADDI = 6'b001000;
  localparam logic [5:0] O_BEQ  = 6'b000100;
  localparam logic [5:0] O_J    = 6'b000010;
  localparam logic [5:0] O_BAD  = 6'b111111;

  initial begin
    e_zero       = '0;
    e_fetch0     = mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0);
    e_fetch1     = mk(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0);
    e_decode     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0);
    e_decode_ill = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 1);
    e_mem_addr   = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0);
    e_mem_rd     = mk(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    e_wb_mem     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
    e_mem_wr     = mk(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    e_exec_r     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0);
    e_wb_r       = mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    e_exec_i     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0);
    e_wb_i       = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    e_branch     = mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0);
    e_jump       = mk(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0);

    // R-type with one fetch stall; mem_ready toggled where it must be ignored
    add(O_R,    1'b0, e_fetch0,     0);
    add(O_R,    1'b1, e_fetch1,     0);
    add(O_R,    1'b0, e_decode,     0);
    add(O_R,    1'b1, e_exec_r,     0);
    add(O_R,    1'b0, e_wb_r,       0);
    // addi
    add(O_ADDI, 1'b1, e_fetch1,     1);
    add(O_ADDI, 1'b1, e_decode,     1);
    add(O_ADDI, 1'b0, e_exec_i,     1);
    add(O_ADDI, 1'b1, e_wb_i,       1);
    // lw, zero wait
    add(O_LW,   1'b1, e_fetch1,     2);
    add(O_LW,   1'b0, e_decode,     2);
    add(O_LW,   1'b0, e_mem_addr,   2);
    add(O_LW,   1'b1, e_mem_rd,     2);
    add(O_LW,   1'b0, e_wb_mem,     2);
    // sw, zero wait; narrow counter wraps 3 -> 0 after this
    add(O_SW,   1'b1, e_fetch1,     3);
    add(O_SW,   1'b1, e_decode,     3);
    add(O_SW,   1'b1, e_mem_addr,   3);
    add(O_SW,   1'b1, e_mem_wr,     3);
    // beq then j
    add(O_BEQ,  1'b1, e_fetch1,     4);
    add(O_BEQ,  1'b0, e_decode,     4);
    add(O_BEQ,  1'b0, e_branch,     4);
    add(O_J,    1'b1, e_fetch1,     5);
    add(O_J,    1'b1, e_decode,     5);
    add(O_J,    1'b0, e_jump,       5);
    // illegal opcode: one-cycle pulse, straight back to FETCH, no retire
    add(O_BAD,  1'b1, e_fetch1,     6);
    add(O_BAD,  1'b1, e_decode_ill, 6);
    add(O_LW,   1'b0, e_fetch0,     6);

    // reset held for two cycles
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_all("reset_hold", e_zero, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset_release", e_zero, 0);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].op, tbl[i].mr, tbl[i].exp, tbl[i].ret);

    // lw with a 3-cycle stall in MEM_RD
    step("lw_fetch",  O_LW, 1'b1, e_fetch1,   6);
    step("lw_decode", O_LW, 1'b1, e_decode,   6);
    step("lw_addr",   O_LW, 1'b1, e_mem_addr, 6);
    for (int i = 0; i < 3; i++)
      step($sformatf("lw_stall%0d", i), O_LW, 1'b0, e_mem_rd, 6);
    step("lw_rd_done", O_LW, 1'b1, e_mem_rd,  6);
    step("lw_wb",      O_LW, 1'b0, e_wb_mem,  6);
    step("lw_retired", O_SW, 1'b0, e_fetch0,  7);

    // reset asserted in the middle of a stalled store
    step("sw_fetch",  O_SW, 1'b1, e_fetch1,   7);
    step("sw_decode", O_SW, 1'b1, e_decode,   7);
    step("sw_addr",   O_SW, 1'b1, e_mem_addr, 7);
    step("sw_stall0", O_SW, 1'b0, e_mem_wr,   7);
    step("sw_stall1", O_SW, 1'b0, e_mem_wr,   7);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("sw_async_reset", e_zero, 0);
    @(negedge clk);
    #1;
    check_all("sw_reset_hold", e_zero, 0);
    rst_n = 1'b1;
    #1;
    check_all("sw_reset_release", e_zero, 0);
    step("restart_fetch0", O_R, 1'b0, e_fetch0, 0);
    step("restart_fetch1", O_R, 1'b1, e_fetch1, 0);
    step("restart_decode", O_R, 1'b1, e_decode, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
